// File: rtl/main_mem.sv
// main_mem: block-granular backing memory behind the data cache.
// Serves one whole-block read (refill) or write (write-back) at a time. A request
// completes a fixed number of cycles after acceptance. It is then held with a
// four-phase ready handshake until both enables drop.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   mem_addr   - request byte address; the low BO_WIDTH bits are ignored
//   mem_rd_en  - block read request, level, held until mem_ready
//   mem_wr_en  - block write request, level, held until mem_ready
//   mem_wr_blk - write block, sampled when the request is accepted
//   mem_rd_blk - read block, valid while mem_ready=1 after a read
//   mem_ready  - request complete, held until both enables are low
//   mem_busy   - high from acceptance until the return to idle
//   mem_err    - sticky error: both enables high, or out-of-range access
module main_mem #(
  parameter int unsigned PA_WIDTH   = 32,
  parameter int unsigned MEM_WIDTH  = 512,
  parameter int unsigned BO_WIDTH   = 6,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 8,
  parameter int unsigned WR_LAT     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PA_WIDTH-1:0]  mem_addr,
  input  logic                 mem_rd_en,
  input  logic                 mem_wr_en,
  input  logic [MEM_WIDTH-1:0] mem_wr_blk,
  output logic [MEM_WIDTH-1:0] mem_rd_blk,
  output logic                 mem_ready,
  output logic                 mem_busy,
  output logic                 mem_err
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam int unsigned HiLsb   = BO_WIDTH + DEPTH_LOG2;
  localparam logic [7:0]  RdLatM1 = 8'(RD_LAT - 1);
  localparam logic [7:0]  WrLatM1 = 8'(WR_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic                   is_wr_q, is_wr_d;
  logic                   oor_q, oor_d;
  logic [MEM_WIDTH-1:0]   wr_blk_q, wr_blk_d;
  logic [MEM_WIDTH-1:0]   rd_blk_q, rd_blk_d;
  logic                   err_q, err_d;
  logic                   mem_we;
  logic                   addr_oor;

  // Storage array, deliberately not reset.
  logic [MEM_WIDTH-1:0]   mem_q [Depth];

  if (PA_WIDTH > HiLsb) begin : g_oor
    assign addr_oor = |mem_addr[PA_WIDTH-1:HiLsb];
  end else begin : g_no_oor
    assign addr_oor = 1'b0;
  end

  // Byte offset within the block plays no part in a block access.
  logic unused_offset;
  assign unused_offset = ^mem_addr[BO_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    is_wr_d  = is_wr_q;
    oor_d    = oor_q;
    wr_blk_d = wr_blk_q;
    rd_blk_d = rd_blk_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_rd_en ^ mem_wr_en) begin
          // Everything the access needs is captured here; inputs are ignored until done.
          state_d  = StBusy;
          idx_d    = mem_addr[BO_WIDTH +: DEPTH_LOG2];
          is_wr_d  = mem_wr_en;
          oor_d    = addr_oor;
          wr_blk_d = mem_wr_blk;
          cnt_d    = mem_wr_en ? WrLatM1 : RdLatM1;
        end else if (mem_rd_en && mem_wr_en) begin
          err_d = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StDone;
          if (oor_q) begin
            err_d = 1'b1;
            if (!is_wr_q) rd_blk_d = '0;
          end else if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rd_blk_d = mem_q[idx_q];
          end
        end
      end
      StDone: begin
        if (!mem_rd_en && !mem_wr_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      is_wr_q  <= 1'b0;
      oor_q    <= 1'b0;
      wr_blk_q <= '0;
      rd_blk_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      is_wr_q  <= is_wr_d;
      oor_q    <= oor_d;
      wr_blk_q <= wr_blk_d;
      rd_blk_q <= rd_blk_d;
      err_q    <= err_d;
    end
  end

  // mem_we is derived from the reset state, so a reset mid-write never commits.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wr_blk_q;
  end

  assign mem_rd_blk = rd_blk_q;
  assign mem_ready  = (state_q == StDone);
  assign mem_busy   = (state_q != StIdle);
  assign mem_err    = err_q;

endmodule

// File: tb/tb_main_mem.sv
// Self-checking bench for main_mem. Two instances: latency 8 (u_dut0) and latency 1 (u_dut1).
// A block-level model (array of blocks, last read block, sticky error) predicts outputs.
module tb_main_mem;

  localparam int unsigned PaW  = 32;
  localparam int unsigned MemW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PaW-1:0]  addr   [2];
  logic            rd_en  [2];
  logic            wr_en  [2];
  logic [MemW-1:0] wblk   [2];
  logic [MemW-1:0] rblk   [2];
  logic            rdy    [2];
  logic            busy   [2];
  logic            err    [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model
  logic [MemW-1:0] m_mem [2][1024];
  logic [MemW-1:0] m_rd  [2];
  logic            m_err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_mem #(
    .PA_WIDTH(32), .MEM_WIDTH(512), .BO_WIDTH(6), .DEPTH_LOG2(10), .RD_LAT(8), .WR_LAT(8)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr[0]), .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]),
    .mem_wr_blk(wblk[0]), .mem_rd_blk(rblk[0]), .mem_ready(rdy[0]), .mem_busy(busy[0]),
    .mem_err(err[0])
  );

  main_mem #(
    .PA_WIDTH(32), .MEM_WIDTH(512), .BO_WIDTH(6), .DEPTH_LOG2(10), .RD_LAT(1), .WR_LAT(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr[1]), .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]),
    .mem_wr_blk(wblk[1]), .mem_rd_blk(rblk[1]), .mem_ready(rdy[1]), .mem_busy(busy[1]),
    .mem_err(err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic logic [MemW-1:0] rnd_blk();
    logic [MemW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [PaW-1:0] addr_of(input int idx);
    logic [5:0] off;
    off = 6'($urandom);
    return {16'h0000, 10'(idx), off};
  endfunction

  task automatic check_eq(input string tag, input logic [MemW-1:0] got,
                          input logic [MemW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete request; entered and left on a falling edge with the instance idle.
  task automatic xfer(input int d, input bit wr, input logic [PaW-1:0] a,
                      input logic [MemW-1:0] b, input int hold);
    int  n;
    int  idx;
    bit  oor;
    bit  seen;
    idx = int'(a[15:6]);
    oor = |a[31:16];
    addr[d]  = a;
    wblk[d]  = b;
    rd_en[d] = !wr;
    wr_en[d] = wr;
    @(negedge clk);
    check_eq("busy_after_accept", busy[d], 1);
    // Scramble address and data while busy; the latched request must win.
    addr[d] = $urandom;
    wblk[d] = rnd_blk();
    n    = 1;
    seen = rdy[d];
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = rdy[d];
    end
    if (!seen) begin
      check_eq("ready_timeout", 0, 1);
    end else begin
      check_eq("latency", n, lat_of(d) + 1);
      if (oor) m_err[d] = 1'b1;
      if (!wr) m_rd[d] = oor ? '0 : m_mem[d][idx];
      else if (!oor) m_mem[d][idx] = b;
      check_eq(wr ? "rd_blk_after_wr" : "rd_blk", rblk[d], m_rd[d]);
      check_eq("err", err[d], m_err[d]);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_eq("ready_held", rdy[d], 1);
        check_eq("busy_held", busy[d], 1);
      end
    end
    rd_en[d] = 1'b0;
    wr_en[d] = 1'b0;
    @(negedge clk);
    check_eq("ready_drop", rdy[d], 0);
    check_eq("busy_drop", busy[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [MemW-1:0] a5;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; rd_en[d] = 1'b0; wr_en[d] = 1'b0; wblk[d] = '0;
      m_rd[d] = '0; m_err[d] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", rdy[d], 0);
      check_eq("rst_busy", busy[d], 0);
      check_eq("rst_rd_blk", rblk[d], 0);
      check_eq("rst_err", err[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write then read of index 0x41, read held 5 cycles.
    a5 = '0;
    for (int i = 0; i < 64; i++) a5[i*8 +: 8] = 8'hA5;
    xfer(0, 1'b1, 32'h0000_1040, a5, 0);
    xfer(0, 1'b0, 32'h0000_107F, a5, 5);
    check_eq("rd_a5", rblk[0], a5);

    // Fill indices 0..15 on both instances.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) xfer(d, 1'b1, addr_of(i), rnd_blk(), 0);

    // Back-to-back write-back to 3 then refill of 7, then read 3.
    for (int d = 0; d < 2; d++) begin
      t0 = cyc;
      xfer(d, 1'b1, addr_of(3), rnd_blk(), 0);
      xfer(d, 1'b0, addr_of(7), '0, 0);
      check_eq("b2b_cycles", cyc - t0, 2 * (lat_of(d) + 2));
      xfer(d, 1'b0, addr_of(3), '0, 0);
    end

    // Randomized mix on both instances.
    for (int k = 0; k < 60; k++) begin
      int d;
      d = k % 2;
      xfer(d, 1'($urandom), addr_of(int'($urandom_range(0, 15))), rnd_blk(),
           int'($urandom_range(0, 3)));
    end

    // Both enables high in idle: error, no access.
    rd_en[0] = 1'b1;
    wr_en[0] = 1'b1;
    wblk[0]  = rnd_blk();
    addr[0]  = addr_of(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("both_en_err", err[0], 1);
      check_eq("both_en_busy", busy[0], 0);
    end
    rd_en[0] = 1'b0;
    wr_en[0] = 1'b0;
    m_err[0] = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, addr_of(3), '0, 0);

    // Out-of-range read on the fast instance.
    xfer(1, 1'b0, 32'h0001_0000, '0, 1);

    // Reset in the middle of a write to index 5.
    addr[0]  = addr_of(5);
    wblk[0]  = rnd_blk();
    wr_en[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("busy_before_rst", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", rdy[0], 0);
    check_eq("midrst_busy", busy[0], 0);
    check_eq("midrst_rd_blk", rblk[0], 0);
    check_eq("midrst_err", err[0], 0);
    check_eq("midrst_err1", err[1], 0);
    wr_en[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_rd[d]  = '0;
      m_err[d] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, addr_of(5), '0, 0);
    xfer(1, 1'b0, addr_of(9), '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
